cpu_divider: RTL and testbench
==============================

// Module: cpu_divider
// PURPOSE
//   Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU ops.
//   Sits beside the ALU in the execute stage. The execute stage holds i_latch
//   high while the op is pending; operands are valid only in the first cycle.
//   Fixed-latency radix-2 restoring division; quotient and remainder produced together.
// PARAMETERS
//   WIDTH      32  operand/result width; only 32 is required to work
// PORTS
//   i_clock        in   1      rising-edge clock
//   i_reset_n      in   1      asynchronous, active-low reset
//   i_latch        in   1      request level; a new op starts on a 0->1 transition
//   i_signed       in   1      1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   i_numerator    in   32     dividend, sampled at the start edge only
//   i_denominator  in   32     divisor, sampled at the start edge only
//   o_ready        out  1      result valid for the most recent request
//   o_result       out  32     quotient
//   o_remainder    out  32     remainder
// BEHAVIOUR
//   Reset (async, i_reset_n=0):
//     - state IDLE; o_ready=0; o_result=0; o_remainder=0; latch_q=0.
//     - An op in flight is aborted; no result appears after release.
//   Start:
//     - start = i_latch & ~latch_q & (state==IDLE|DONE); latch_q is i_latch registered.
//     - At the start edge, capture i_signed, |num|, |den|, and both sign bits.
//       Magnitudes are taken only when signed.
//     - o_ready = done_q & ~start (combinational mask), so o_ready is 0 in the
//       request's first cycle even if a previous result is still held.
//   States: IDLE -> (start) BUSY (32 iterations) -> FIX (1 cycle) -> DONE.
//     - BUSY: one quotient bit per cycle, MSB first.
//       Shift {rem,quo} left; rem' = rem - den if rem >= den (quotient bit 1),
//       otherwise rem is kept.
//     - FIX: apply signs and special cases, write o_result/o_remainder, set done_q.
//     - DONE: results held stable; only a new start edge leaves DONE.
//   Latency: start edge at cycle 0; o_ready first high after edge 33.
//     - Latency is identical for every operand value, including divide-by-zero.
//   i_latch behaviour:
//     - Held high after o_ready does not restart.
//     - A rising edge while BUSY/FIX is ignored.
//     - Dropping i_latch mid-op does not abort.
//   Sign rules (signed mode):
//     - Quotient negative iff operand signs differ.
//     - Remainder takes the sign of the numerator.
//   Special cases (RISC-V):
//     - den==0: quotient=32'hFFFFFFFF (both modes), remainder=numerator.
//     - signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
//   Outputs change only in FIX or on reset.
// TESTING
//   - DIVU 100/7 -> o_ready exactly 34 edges after start; result=14, rem=2.
//   - DIV -7/2 (0xFFFFFFF9,2) -> result=0xFFFFFFFD, rem=0xFFFFFFFF;
//     DIV 7/-2 -> 0xFFFFFFFD, rem=1.
//   - Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, rem 5;
//     DIV -5/0 -> 0xFFFFFFFF, rem 0xFFFFFFFB.
//   - Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, rem 0;
//     DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF, rem 0.
//   - Hold i_latch high 5 cycles past o_ready -> no restart, outputs stable.
//     Drop then raise -> o_ready=0 in that cycle, new result 34 edges later.
//   - Assert i_reset_n=0 at iteration 10 -> o_ready/o_result/o_remainder=0
//     immediately and stay 0 after release with i_latch low.

Source files
------------

// File: rtl/cpu_divider.sv
// cpu_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A request starts on a rising edge of i_latch. Division always runs on
// magnitudes for a fixed 32 iterations, then one fix-up cycle applies signs and
// the RISC-V divide-by-zero rule. The result is held until the next request.
module cpu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_latch,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_numerator,
    input  logic [WIDTH-1:0] i_denominator,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic             latch_reg;
    logic             done_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] den_reg;
    logic             num_neg_reg;
    logic             den_neg_reg;
    logic             den_zero_reg;
    logic             signed_reg;

    logic             start;
    logic             last_iter;
    logic             num_neg;
    logic             den_neg;
    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             quo_neg;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // A request is accepted only from IDLE/DONE; edges while busy are ignored.
    assign start     = i_latch & ~latch_reg & ((state_reg == IDLE) || (state_reg == DONE));
    assign last_iter = (count_reg == CW'(WIDTH - 1));

    // The held result is masked in the request's first cycle.
    assign o_ready = done_reg & ~start;

    // Operand magnitudes; sign bits only count in signed mode.
    always_comb begin
        num_neg = i_signed & i_numerator[WIDTH-1];
        den_neg = i_signed & i_denominator[WIDTH-1];
        num_mag = num_neg ? (~i_numerator + 1'b1) : i_numerator;
        den_mag = den_neg ? (~i_denominator + 1'b1) : i_denominator;
    end

    // One restoring step: shift {rem,quo} left, subtract den if it fits.
    // The shifted remainder needs one extra bit, as it can reach 2*den-1.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        diff      = rem_shift - {1'b0, den_reg};
        fits      = ~diff[WIDTH];
        rem_step  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {quo_reg[WIDTH-2:0], fits};
    end

    // Sign fix-up. The 0x80000000 / -1 overflow case needs no special handling:
    // magnitude division gives 0x80000000 with rem 0 and the signs agree.
    // Divide-by-zero: the magnitude loop leaves rem=|num|, which the numerator
    // sign turns back into num; only the quotient must be forced to all ones.
    always_comb begin
        quo_neg = signed_reg & (num_neg_reg ^ den_neg_reg);
        if (den_zero_reg) begin
            quo_fix = '1;
        end else begin
            quo_fix = quo_neg ? (~quo_reg + 1'b1) : quo_reg;
        end
        rem_fix = num_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> BUSY (32 cycles) -> FIX -> DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (start) state_next = BUSY;
            default: state_next = IDLE;
        endcase
    end

    // Request edge detector.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            latch_reg <= 1'b0;
        end else begin
            latch_reg <= i_latch;
        end
    end

    // Datapath: operand capture, iteration, and result write in FIX.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_reg    <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            den_reg      <= '0;
            num_neg_reg  <= 1'b0;
            den_neg_reg  <= 1'b0;
            den_zero_reg <= 1'b0;
            signed_reg   <= 1'b0;
            done_reg     <= 1'b0;
            o_result     <= '0;
            o_remainder  <= '0;
        end else if (start) begin
            count_reg    <= '0;
            quo_reg      <= num_mag;
            rem_reg      <= '0;
            den_reg      <= den_mag;
            num_neg_reg  <= num_neg;
            den_neg_reg  <= den_neg;
            den_zero_reg <= (i_denominator == '0);
            signed_reg   <= i_signed;
            done_reg     <= 1'b0;
        end else if (state_reg == BUSY) begin
            count_reg <= count_reg + CW'(1);
            quo_reg   <= quo_step;
            rem_reg   <= rem_step;
        end else if (state_reg == FIX) begin
            o_result    <= quo_fix;
            o_remainder <= rem_fix;
            done_reg    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_divider.sv
// tb_cpu_divider: directed and randomized checks of cpu_divider against a
// behavioural RV32M division model built on plain signed/unsigned arithmetic.
module tb_cpu_divider;

    logic        i_clock;
    logic        i_reset_n;
    logic        i_latch;
    logic        i_signed;
    logic [31:0] i_numerator;
    logic [31:0] i_denominator;
    logic        o_ready;
    logic [31:0] o_result;
    logic [31:0] o_remainder;

    int tests;
    int fails;

    localparam int LATENCY = 34;
    localparam int BUDGET  = 60;

    cpu_divider #(.WIDTH(32)) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_latch       (i_latch),
        .i_signed      (i_signed),
        .i_numerator   (i_numerator),
        .i_denominator (i_denominator),
        .o_ready       (o_ready),
        .o_result      (o_result),
        .o_remainder   (o_remainder)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Reference: RISC-V division semantics from plain arithmetic.
    function automatic void model(input logic sg, input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sn;
        logic signed [31:0] sd;
        sn = n;
        sd = d;
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = n;
        end else if (sg) begin
            if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = sn / sd;
                r = sn % sd;
            end
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    // Runs one op, checks first-cycle mask, latency and results, then optionally
    // holds i_latch high for 'hold' cycles checking for no restart.
    task automatic do_op(input logic sg, input logic [31:0] n, input logic [31:0] d,
                         input int hold, input string name);
        logic [31:0] eq;
        logic [31:0] er;
        int lat;
        bit got;
        model(sg, n, d, eq, er);
        @(negedge i_clock);
        i_latch = 1'b1;
        i_signed = sg;
        i_numerator = n;
        i_denominator = d;
        #1;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s first_cycle_ready: got %b want 0", name, o_ready);
        end
        lat = 0;
        got = 0;
        while (!got && lat < BUDGET) begin
            @(posedge i_clock);
            #1;
            lat++;
            if (lat == 1) begin
                // operands must have been captured at the start edge only
                i_signed = ~sg;
                i_numerator = $urandom;
                i_denominator = $urandom;
            end
            if (o_ready === 1'b1) got = 1;
        end
        tests++;
        if (!got || lat != LATENCY) begin
            fails++;
            $display("FAIL %s latency: got %0d (ready=%b) want %0d", name, lat, got, LATENCY);
        end
        tests++;
        if (o_result !== eq || o_remainder !== er) begin
            fails++;
            $display("FAIL %s result: got q=%h r=%h want q=%h r=%h", name, o_result, o_remainder, eq, er);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clock);
            #1;
            tests++;
            if (o_ready !== 1'b1 || o_result !== eq || o_remainder !== er) begin
                fails++;
                $display("FAIL %s hold%0d: got rdy=%b q=%h r=%h want rdy=1 q=%h r=%h",
                         name, i, o_ready, o_result, o_remainder, eq, er);
            end
        end
        $display("[TB] %s sg=%0b n=%h d=%h -> q=%h r=%h lat=%0d", name, sg, n, d, o_result, o_remainder, lat);
        @(negedge i_clock);
        i_latch = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_latch = 1'b0;
        i_signed = 1'b0;
        i_numerator = 32'd0;
        i_denominator = 32'd0;
        repeat (3) @(posedge i_clock);
        #1;
        tests++;
        if (o_ready !== 1'b0 || o_result !== 32'd0 || o_remainder !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b q=%h r=%h want 0 0 0", o_ready, o_result, o_remainder);
        end
        $display("[TB] reset rdy=%b q=%h r=%h", o_ready, o_result, o_remainder);
        @(negedge i_clock);
        i_reset_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
        do_op(1'b0, 32'd5, 32'd0, 0, "divu_5_0");
        do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0, "div_m5_0");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_big");
    endtask

    task automatic test_hold();
        do_op(1'b0, 32'd1000, 32'd33, 5, "hold_high");
        // back-to-back request right after drop: first-cycle mask checked in do_op
        do_op(1'b1, 32'hFFFF_FC18, 32'd33, 0, "restart");
    endtask

    // Drop i_latch mid-op and raise it again while busy: neither aborts nor restarts.
    task automatic test_busy_edge();
        logic [31:0] eq;
        logic [31:0] er;
        int lat;
        bit got;
        model(1'b1, 32'd123456, 32'hFFFF_FFF3, eq, er);
        @(negedge i_clock);
        i_latch = 1'b1;
        i_signed = 1'b1;
        i_numerator = 32'd123456;
        i_denominator = 32'hFFFF_FFF3;
        lat = 0;
        got = 0;
        while (!got && lat < BUDGET) begin
            @(posedge i_clock);
            #1;
            lat++;
            if (lat == 5) i_latch = 1'b0;
            if (lat == 8) begin
                i_latch = 1'b1;
                i_signed = 1'b0;
                i_numerator = 32'd9;
                i_denominator = 32'd4;
            end
            if (o_ready === 1'b1) got = 1;
        end
        tests++;
        if (!got || lat != LATENCY) begin
            fails++;
            $display("FAIL busy_edge latency: got %0d (ready=%b) want %0d", lat, got, LATENCY);
        end
        tests++;
        if (o_result !== eq || o_remainder !== er) begin
            fails++;
            $display("FAIL busy_edge result: got q=%h r=%h want q=%h r=%h", o_result, o_remainder, eq, er);
        end
        repeat (3) @(posedge i_clock);
        #1;
        tests++;
        if (o_ready !== 1'b1 || o_result !== eq) begin
            fails++;
            $display("FAIL busy_edge no_restart: got rdy=%b q=%h want rdy=1 q=%h", o_ready, o_result, eq);
        end
        $display("[TB] busy_edge q=%h r=%h lat=%0d", o_result, o_remainder, lat);
        @(negedge i_clock);
        i_latch = 1'b0;
    endtask

    // Reset at iteration 10 clears outputs at once and nothing appears later.
    task automatic test_abort();
        @(negedge i_clock);
        i_latch = 1'b1;
        i_signed = 1'b0;
        i_numerator = 32'd77777;
        i_denominator = 32'd3;
        repeat (11) @(posedge i_clock);
        @(negedge i_clock);
        i_reset_n = 1'b0;
        i_latch = 1'b0;
        #1;
        tests++;
        if (o_ready !== 1'b0 || o_result !== 32'd0 || o_remainder !== 32'd0) begin
            fails++;
            $display("FAIL abort_immediate: got rdy=%b q=%h r=%h want 0 0 0", o_ready, o_result, o_remainder);
        end
        @(negedge i_clock);
        i_reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clock);
            #1;
            tests++;
            if (o_ready !== 1'b0 || o_result !== 32'd0 || o_remainder !== 32'd0) begin
                fails++;
                $display("FAIL abort_after%0d: got rdy=%b q=%h r=%h want 0 0 0",
                         i, o_ready, o_result, o_remainder);
            end
        end
        $display("[TB] abort rdy=%b q=%h r=%h", o_ready, o_result, o_remainder);
    endtask

    task automatic test_random();
        logic [31:0] n;
        logic [31:0] d;
        logic sg;
        for (int k = 0; k < 150; k++) begin
            sg = 1'($urandom_range(0, 1));
            n = $urandom;
            case ($urandom_range(0, 7))
                0: d = 32'd0;
                1: d = 32'hFFFF_FFFF;
                2: d = 32'($urandom_range(1, 15));
                3: d = n >> $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) n = 32'h8000_0000;
            do_op(sg, n, d, 0, "random");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_hold();
        test_busy_edge();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
